// File: rtl/dram_result_reader_pkg.sv
// Shared definitions for the DRAM result reader: FSM state encoding and
// UART 8N1 frame constants.
package dram_result_reader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic START_LVL  = 1'b0;
    localparam logic STOP_LVL   = 1'b1;
    localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/dram_result_reader_uart_tx_core.sv
// UART 8N1 transmitter: one frame per load pulse, LSB first, with a
// registered tx line that idles high.
module uart_tx_core
    import dram_result_reader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_abort,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic [3:0] o_bit_idx,
    output logic       o_bit_last,
    output logic       o_tx_done
);

    localparam int                BAUD_W        = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_ONE      = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE      = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]        BIT_STOP      = 4'(FRAME_BITS - 1);
    localparam logic [3:0]        BIT_LAST_DATA = 4'(FRAME_BITS - 2);

    logic              r_active;
    logic              r_tx;
    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bit;
    logic [7:0]        r_shift;
    logic              w_bit_last;

    assign w_bit_last = r_active && (r_baud == BAUD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_tx     <= STOP_LVL;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
        end else if (i_abort) begin
            r_active <= 1'b0;
            r_tx     <= STOP_LVL;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_tx     <= START_LVL;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= i_data;
        end else if (w_bit_last) begin
            r_baud <= '0;
            if (r_bit == BIT_STOP) begin
                r_active <= 1'b0;
            end else begin
                r_bit <= r_bit + 4'd1;
                if (r_bit == BIT_LAST_DATA) begin
                    r_tx <= STOP_LVL;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                end
            end
        end else if (r_active) begin
            r_baud <= r_baud + BAUD_ONE;
        end
    end

    // Completion is flagged one cycle early so the caller's bookkeeping
    // cycle overlaps the final stop-bit cycle.
    assign o_tx_done  = r_active && (r_bit == BIT_STOP) && (r_baud == BAUD_PRE);
    assign o_tx       = r_tx;
    assign o_bit_idx  = r_bit;
    assign o_bit_last = w_bit_last;

endmodule

// File: rtl/dram_result_reader.sv
// Dumps byte_count bytes from DRAM starting at base_addr onto a UART line
// after a start edge; owns the DRAM read port only while fetching.
module dram_result_reader
    import dram_result_reader_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] byte_count,
    input  logic [DATA_W-1:0] dm_q,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              mem_own,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sent_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);
    localparam logic [1:0]        LAT_LAST      = 2'(READ_LATENCY - 1);
    localparam logic [3:0]        BIT_LAST_DATA = 4'(FRAME_BITS - 2);

    state_t            r_state, w_state_nxt;
    logic              r_start_d;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [ADDR_W-1:0] r_rem, w_rem_nxt;
    logic [ADDR_W-1:0] r_sent, w_sent_nxt;
    logic [1:0]        r_wait, w_wait_nxt;
    logic              r_busy, w_busy_nxt;
    logic              w_start_edge, w_abort, w_load;
    logic              w_tx, w_bit_last, w_tx_done;
    logic [3:0]        w_bit_idx;

    assign w_start_edge = start && !r_start_d;
    assign w_abort      = abort && (r_state != ST_IDLE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b0;
            r_addr    <= '0;
            r_dm_addr <= '0;
            r_rem     <= '0;
            r_sent    <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= start;
            r_addr    <= w_addr_nxt;
            r_rem     <= w_rem_nxt;
            r_sent    <= w_sent_nxt;
            r_wait    <= w_wait_nxt;
            r_busy    <= w_busy_nxt;
            // The DRAM address only moves when a fetch begins.
            if (w_state_nxt == ST_FETCH) r_dm_addr <= w_addr_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_rem_nxt   = r_rem;
        w_sent_nxt  = r_sent;
        w_wait_nxt  = r_wait;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_busy_nxt = 1'b0;
                    if (w_start_edge && !abort) begin
                        w_busy_nxt  = 1'b1;
                        w_addr_nxt  = base_addr;
                        w_rem_nxt   = byte_count;
                        w_sent_nxt  = '0;
                        w_state_nxt = (byte_count == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait == LAT_LAST) w_state_nxt = ST_LOAD;
                    else                    w_wait_nxt  = r_wait + 2'd1;
                end
                ST_LOAD: begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_START;
                end
                ST_START: if (w_bit_last) w_state_nxt = ST_DATA;
                ST_DATA:  if (w_bit_last && (w_bit_idx == BIT_LAST_DATA)) w_state_nxt = ST_STOP;
                ST_STOP:  if (w_tx_done) w_state_nxt = ST_NEXT;
                ST_NEXT: begin
                    w_sent_nxt  = r_sent + ADDR_ONE;
                    w_addr_nxt  = r_addr + ADDR_ONE;
                    w_rem_nxt   = r_rem - ADDR_ONE;
                    w_state_nxt = (r_rem == ADDR_ONE) ? ST_DONE : ST_FETCH;
                end
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_core (
        .clock     (clock),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_abort   (w_abort),
        .i_data    (dm_q),
        .o_tx      (w_tx),
        .o_bit_idx (w_bit_idx),
        .o_bit_last(w_bit_last),
        .o_tx_done (w_tx_done)
    );

    assign dm_addr  = r_dm_addr;
    assign mem_own  = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_LOAD);
    assign tx       = w_tx;
    assign busy     = r_busy;
    assign done     = (r_state == ST_DONE);
    assign sent_cnt = r_sent;

endmodule

// File: tb/tb_dram_result_reader.sv
// Directed scoreboard bench for dram_result_reader: expected bytes and
// addresses are queued with each stimulus step and checked by monitors.
module tb_dram_result_reader;

    localparam int ADDR_W = 16;
    localparam int CPB    = 4;
    localparam int LAT    = 1;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] byte_count;
    logic [7:0]        dm_q;
    logic [ADDR_W-1:0] dm_addr;
    logic              mem_own;
    logic              tx;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sent_cnt;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_q [$];
    logic [15:0] addr_q [$];
    int          fstart [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cyc = 0, own_cyc = 0, txlow_cyc = 0, done_cnt = 0;
    int drop_req = 0, drop_done = 0;
    logic prev_own = 1'b0;

    dram_result_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (8),
        .CLKS_PER_BIT(CPB),
        .READ_LATENCY(LAT)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .byte_count(byte_count),
        .dm_q      (dm_q),
        .dm_addr   (dm_addr),
        .mem_own   (mem_own),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    always #5 clock = ~clock;

    // DRAM on the inverted clock: one-cycle read latency.
    always @(negedge clock) dm_q <= mem[dm_addr];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Activity counters and DRAM address scoreboard.
    always @(negedge clock) begin
        if (busy === 1'b1)    busy_cyc++;
        if (mem_own === 1'b1) own_cyc++;
        if (tx === 1'b0)      txlow_cyc++;
        if (done === 1'b1)    done_cnt++;
        if (mem_own === 1'b1 && prev_own === 1'b0) begin
            check("addr_expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) check("dm_addr", 32'(dm_addr), 32'(addr_q.pop_front()));
        end
        prev_own = mem_own;
    end

    // UART frame decoder and byte scoreboard.
    initial begin : uart_mon
        logic [9:0] bits;
        bit         stable;
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                fstart.push_back(cyc);
                stable = 1'b1;
                bits   = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clock);
                        if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (drop_req > drop_done) begin
                    drop_done++;
                end else begin
                    check("frame_stable", 32'(stable), 32'd1);
                    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_bits", 32'(bits), 32'({1'b1, e, 1'b0}));
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_frames(input int n, input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            if (fstart.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int c0, fs, b0, o0, t0, d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; byte_count = '0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_own", 32'(mem_own), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Basic dump of three bytes
        mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C; mem[16'h0012] = 8'hFF;
        base_addr = 16'h0010; byte_count = 16'd3;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'hFF);
        addr_q.push_back(16'h0010); addr_q.push_back(16'h0011); addr_q.push_back(16'h0012);
        fs = fstart.size(); d0 = done_cnt; c0 = cyc;
        pulse_start();
        wait_done(400);
        check("basic_sent_cnt", 32'(sent_cnt), 32'd3);
        repeat (5) @(negedge clock);
        check("basic_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_frames", 32'(fstart.size() - fs), 32'd3);
        if (fstart.size() - fs == 3) begin
            check("basic_first_latency", 32'(fstart[fs] - c0), 32'd4);
            check("basic_spacing_1", 32'(fstart[fs+1] - fstart[fs]), 32'(10*CPB + LAT + 2));
            check("basic_spacing_2", 32'(fstart[fs+2] - fstart[fs+1]), 32'(10*CPB + LAT + 2));
        end

        // Zero byte count
        base_addr = 16'h0100; byte_count = 16'd0;
        b0 = busy_cyc; o0 = own_cyc; t0 = txlow_cyc; d0 = done_cnt;
        pulse_start();
        repeat (8) @(negedge clock);
        check("zero_busy_cycles", 32'(busy_cyc - b0), 32'd2);
        check("zero_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("zero_mem_own", 32'(own_cyc - o0), 32'd0);
        check("zero_tx_low", 32'(txlow_cyc - t0), 32'd0);

        // Address wrap
        mem[16'hFFFF] = 8'h81; mem[16'h0000] = 8'h5A;
        base_addr = 16'hFFFF; byte_count = 16'd2;
        exp_q.push_back(8'h81); exp_q.push_back(8'h5A);
        addr_q.push_back(16'hFFFF); addr_q.push_back(16'h0000);
        d0 = done_cnt;
        pulse_start();
        wait_done(300);
        check("wrap_sent_cnt", 32'(sent_cnt), 32'd2);
        repeat (5) @(negedge clock);
        check("wrap_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Abort during the data bits of the second byte
        mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33; mem[16'h0023] = 8'h44;
        base_addr = 16'h0020; byte_count = 16'd4;
        exp_q.push_back(8'h11);
        addr_q.push_back(16'h0020); addr_q.push_back(16'h0021);
        fs = fstart.size(); d0 = done_cnt;
        pulse_start();
        wait_frames(fs + 2, 200);
        repeat (16) @(negedge clock);
        drop_req++;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_mem_own", 32'(mem_own), 32'd0);
        check("abort_sent_cnt", 32'(sent_cnt), 32'd1);
        repeat (50) @(negedge clock);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        mem[16'h0030] = 8'hC3;
        base_addr = 16'h0030; byte_count = 16'd1;
        exp_q.push_back(8'hC3); addr_q.push_back(16'h0030);
        pulse_start();
        wait_done(200);
        check("restart_sent_cnt", 32'(sent_cnt), 32'd1);
        repeat (5) @(negedge clock);

        // Start edge while busy is ignored; input changes have no effect
        mem[16'h0040] = 8'h96; mem[16'h0041] = 8'h0F;
        base_addr = 16'h0040; byte_count = 16'd2;
        exp_q.push_back(8'h96); exp_q.push_back(8'h0F);
        addr_q.push_back(16'h0040); addr_q.push_back(16'h0041);
        fs = fstart.size(); d0 = done_cnt;
        pulse_start();
        repeat (20) @(negedge clock);
        base_addr = 16'h0099; byte_count = 16'd7;
        pulse_start();
        wait_done(300);
        check("busy_start_sent_cnt", 32'(sent_cnt), 32'd2);
        repeat (60) @(negedge clock);
        check("busy_start_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_start_frames", 32'(fstart.size() - fs), 32'd2);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Asynchronous reset during the start bit
        mem[16'h0050] = 8'hE7;
        base_addr = 16'h0050; byte_count = 16'd2;
        addr_q.push_back(16'h0050);
        fs = fstart.size();
        pulse_start();
        wait_frames(fs + 1, 100);
        drop_req++;
        @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        check("areset_tx", 32'(tx), 32'd1);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_mem_own", 32'(mem_own), 32'd0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        b0 = busy_cyc; o0 = own_cyc; t0 = txlow_cyc; d0 = done_cnt;
        repeat (60) @(negedge clock);
        check("areset_idle_busy", 32'(busy_cyc - b0), 32'd0);
        check("areset_idle_own", 32'(own_cyc - o0), 32'd0);
        check("areset_idle_tx", 32'(txlow_cyc - t0), 32'd0);
        check("areset_idle_done", 32'(done_cnt - d0), 32'd0);
        check("areset_sent_cnt", 32'(sent_cnt), 32'd0);
        mem[16'h0060] = 8'h3A;
        base_addr = 16'h0060; byte_count = 16'd1;
        exp_q.push_back(8'h3A); addr_q.push_back(16'h0060);
        pulse_start();
        wait_done(200);
        check("areset_restart_sent", 32'(sent_cnt), 32'd1);
        repeat (10) @(negedge clock);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
